// File: rtl/fft_result_scanner.sv
// fft_result_scanner: captures the four FFT result words into a shadow
// snapshot and scans the selected word onto an 8-digit multiplexed hex
// display. The displayed word changes either on a manual next_word edge or
// by timed auto-rotation. Display contents only ever change at a frame
// boundary, so the display never shows a torn word.
module fft_result_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int WORD_HOLD   = 2000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        out_valid,
  input  logic [31:0] dout1_re,
  input  logic [31:0] dout1_im,
  input  logic [31:0] dout2_re,
  input  logic [31:0] dout2_im,
  input  logic        freeze,
  input  logic        next_word,
  input  logic        auto_rotate,
  output logic [2:0]  an,
  output logic [3:0]  d,
  output logic [6:0]  seg,
  output logic [1:0]  word_sel,
  output logic        snap_valid
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int FW = (WORD_HOLD > 1) ? $clog2(WORD_HOLD) : 1;
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(WORD_HOLD - 1);
  localparam logic [6:0]    GLYPH_ZERO = 7'b1000000;

  logic [31:0]   shadow [4];
  logic [31:0]   display [4];
  logic          shadow_new;
  logic [RW-1:0] refresh_cnt;
  logic [2:0]    digit;
  logic [FW-1:0] frame_cnt;
  logic          pending_adv;
  logic          next_word_q;

  logic          tick;
  logic          frame_end;
  logic          capture;
  logic          rise;
  logic          auto_evt;
  logic          advance;
  logic [31:0]   cur_word;
  logic [3:0]    nibble;

  // Hex digit to active-low segment pattern (g..a)
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Per-cycle control decode: refresh tick, frame boundary, capture and advance requests
  always_comb begin
    tick      = (refresh_cnt == REF_LAST);
    frame_end = tick && (digit == 3'd7);
    capture   = out_valid && !freeze;
    rise      = next_word && !next_word_q;
    auto_evt  = auto_rotate && (frame_cnt == FRAME_LAST);
    advance   = pending_adv || auto_evt;
    cur_word  = display[word_sel];
    nibble    = cur_word[{digit, 2'b00} +: 4];
  end

  // Shadow capture and frame-aligned transfer to the display words; the
  // transfer reads the old shadow so a same-cycle capture waits a frame
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        shadow[i]  <= '0;
        display[i] <= '0;
      end
      shadow_new <= 1'b0;
      snap_valid <= 1'b0;
    end else begin
      if (frame_end && shadow_new) begin
        for (int i = 0; i < 4; i++) display[i] <= shadow[i];
        snap_valid <= 1'b1;
      end
      if (capture) begin
        shadow[0]  <= dout1_re;
        shadow[1]  <= dout1_im;
        shadow[2]  <= dout2_re;
        shadow[3]  <= dout2_im;
        shadow_new <= 1'b1;
      end else if (frame_end) begin
        shadow_new <= 1'b0;
      end
    end
  end

  // Digit slot timing: refresh counter wraps every REFRESH_DIV clocks and steps the digit
  always_ff @(posedge clock) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit       <= '0;
    end else if (tick) begin
      refresh_cnt <= '0;
      digit       <= digit + 3'd1;
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  // Word selection: manual edge requests and hold-timer rotation, applied only at frame end
  always_ff @(posedge clock) begin
    if (reset) begin
      word_sel    <= '0;
      frame_cnt   <= '0;
      pending_adv <= 1'b0;
      next_word_q <= 1'b0;
    end else begin
      next_word_q <= next_word;
      if (frame_end) begin
        if (advance) begin
          word_sel    <= word_sel + 2'd1;
          frame_cnt   <= '0;
          pending_adv <= rise;
        end else begin
          if (frame_cnt != FRAME_LAST) frame_cnt <= frame_cnt + FW'(1);
          if (rise) pending_adv <= 1'b1;
        end
      end else if (rise) begin
        pending_adv <= 1'b1;
      end
    end
  end

  // Registered display drive, one clock behind the digit and word registers
  always_ff @(posedge clock) begin
    if (reset) begin
      an  <= '0;
      d   <= '0;
      seg <= GLYPH_ZERO;
    end else begin
      an  <= digit;
      d   <= nibble;
      seg <= hex_to_seg(nibble);
    end
  end

endmodule

// File: tb/tb_fft_result_scanner.sv
// tb_fft_result_scanner: directed phases followed by randomized traffic,
// every cycle compared against a reference model that derives digit and
// frame position from the absolute cycle count since reset.
module tb_fft_result_scanner;

  localparam int RD = 4;
  localparam int WH = 2;
  localparam int FRAME = 8 * RD;

  logic        clock;
  logic        reset;
  logic        out_valid;
  logic [31:0] dout1_re, dout1_im, dout2_re, dout2_im;
  logic        freeze;
  logic        next_word;
  logic        auto_rotate;
  logic [2:0]  an;
  logic [3:0]  d;
  logic [6:0]  seg;
  logic [1:0]  word_sel;
  logic        snap_valid;

  int num_checks = 0;
  int num_errors = 0;

  // Reference model state
  logic [6:0]  glyph [16];
  logic [31:0] m_shadow [4];
  logic [31:0] m_disp [4];
  int          m_cyc;
  bit          m_shadow_new, m_snap, m_pending, m_prev_nw;
  int          m_wsel, m_frames;
  int          m_an, m_d;
  logic [6:0]  m_seg;

  fft_result_scanner #(.REFRESH_DIV(RD), .WORD_HOLD(WH)) dut (
    .clock(clock), .reset(reset), .out_valid(out_valid),
    .dout1_re(dout1_re), .dout1_im(dout1_im),
    .dout2_re(dout2_re), .dout2_im(dout2_im),
    .freeze(freeze), .next_word(next_word), .auto_rotate(auto_rotate),
    .an(an), .d(d), .seg(seg), .word_sel(word_sel), .snap_valid(snap_valid)
  );

  // Free-running clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, m_cyc, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic val, input logic frz,
                               input logic nw, input logic aut,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic [31:0] e);
    reset = rst; out_valid = val; freeze = frz; next_word = nw; auto_rotate = aut;
    dout1_re = a; dout1_im = b; dout2_re = c; dout2_im = e;
  endtask

  // Advance the model across one rising edge using the currently driven inputs
  task automatic model_step();
    int digit_now;
    bit frame_end, rise, adv;
    int nib;
    if (reset) begin
      m_cyc = 0;
      for (int i = 0; i < 4; i++) begin m_shadow[i] = '0; m_disp[i] = '0; end
      m_shadow_new = 0; m_snap = 0; m_pending = 0; m_prev_nw = 0;
      m_wsel = 0; m_frames = 0;
      m_an = 0; m_d = 0; m_seg = glyph[0];
    end else begin
      digit_now = (m_cyc / RD) % 8;
      frame_end = (m_cyc % FRAME) == FRAME - 1;
      nib   = int'((m_disp[m_wsel] >> (4 * digit_now)) & 32'hF);
      m_an  = digit_now;
      m_d   = nib;
      m_seg = glyph[nib];
      rise  = next_word && !m_prev_nw;
      if (frame_end) begin
        if (m_shadow_new) begin
          for (int i = 0; i < 4; i++) m_disp[i] = m_shadow[i];
          m_snap = 1;
          m_shadow_new = 0;
        end
        adv = m_pending || (auto_rotate && m_frames == WH - 1);
        if (adv) begin
          m_wsel    = (m_wsel + 1) % 4;
          m_frames  = 0;
          m_pending = rise;
        end else begin
          m_frames  = (m_frames + 1 > WH - 1) ? WH - 1 : m_frames + 1;
          m_pending = m_pending || rise;
        end
      end else begin
        m_pending = m_pending || rise;
      end
      if (out_valid && !freeze) begin
        m_shadow[0] = dout1_re; m_shadow[1] = dout1_im;
        m_shadow[2] = dout2_re; m_shadow[3] = dout2_im;
        m_shadow_new = 1;
      end
      m_prev_nw = next_word;
      m_cyc++;
    end
  endtask

  // One clock with comparison of every output against the model
  task automatic tick_cycle();
    model_step();
    @(negedge clock);
    checkOutput("an", 32'(an), 32'(m_an));
    checkOutput("d", 32'(d), 32'(m_d));
    checkOutput("seg", 32'(seg), 32'(m_seg));
    checkOutput("word_sel", 32'(word_sel), 32'(m_wsel));
    checkOutput("snap_valid", 32'(snap_valid), 32'(m_snap));
  endtask

  task automatic idle(input int n, input logic nw, input logic aut);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, nw, aut, $urandom, $urandom, $urandom, $urandom);
      tick_cycle();
    end
  endtask

  // Main stimulus sequence
  initial begin
    glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
    glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010; glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000;
    glyph[8]  = 7'b0000000; glyph[9]  = 7'b0010000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
    glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110; glyph[15] = 7'b0001110;
    m_cyc = 0;

    $display("[TB] reset and idle scan");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
      tick_cycle();
    end
    idle(20, 1'b0, 1'b0);

    $display("[TB] single capture of 89ABCDEF");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h89ABCDEF, $urandom, $urandom, $urandom);
    tick_cycle();
    idle(2 * FRAME + 6, 1'b0, 1'b0);

    $display("[TB] freeze blocks capture");
    for (int k = 0; k < FRAME + 8; k++) begin
      applyStimulus(1'b0, (k % 3) == 0, 1'b1, 1'b0, 1'b0, 32'h12345678, $urandom, $urandom, $urandom);
      tick_cycle();
    end
    idle(FRAME, 1'b0, 1'b0);

    $display("[TB] next_word held for three frames");
    idle(3 * FRAME, 1'b1, 1'b0);
    idle(FRAME + 5, 1'b0, 1'b0);

    $display("[TB] auto rotation with a manual edge");
    idle(5 * FRAME, 1'b0, 1'b1);
    for (int k = 0; k < 64 && (m_cyc % (2 * FRAME)) != 20; k++) idle(1, 1'b0, 1'b1);
    idle(4, 1'b1, 1'b1);
    idle(5 * FRAME, 1'b0, 1'b1);

    $display("[TB] capture on frame end");
    for (int k = 0; k < 64 && (m_cyc % FRAME) != FRAME - 1; k++) idle(1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFEDC0A5B, $urandom, $urandom, $urandom);
    tick_cycle();
    idle(2 * FRAME + 4, 1'b0, 1'b0);

    $display("[TB] reset mid-frame");
    for (int k = 0; k < 64 && (m_cyc % FRAME) != 13; k++) idle(1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    tick_cycle();
    idle(10, 1'b0, 1'b0);

    $display("[TB] randomized traffic");
    begin
      logic nw_r = 1'b0;
      logic au_r = 1'b0;
      for (int k = 0; k < 2500; k++) begin
        if ($urandom_range(0, 19) == 0) nw_r = ~nw_r;
        if ($urandom_range(0, 99) == 0) au_r = ~au_r;
        applyStimulus($urandom_range(0, 399) == 0, $urandom_range(0, 9) == 0,
                      $urandom_range(0, 3) == 0, nw_r, au_r,
                      $urandom, $urandom, $urandom, $urandom);
        tick_cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/fft_result_scanner.md
Name: fft_result_scanner

Overview:
- Consumes the four 32-bit FFT result words (out1 Re/Im, out2 Re/Im) and captures a tear-free snapshot.
- Time-multiplexes the selected word onto the 8-digit hex display: 3-bit digit index, 4-bit nibble, 7-segment pattern.
- Selects the displayed word by auto-rotation or a manual strobe.
- Sits directly downstream of the FFT core and replaces ad-hoc nibble muxing at the top level.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot; must be >= 2.
- WORD_HOLD, 2000: full 8-digit frames a word is shown before auto-rotation; must be >= 1.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- out_valid  in  1  FFT result valid this cycle
- dout1_re  in  32  FFT output 1, real part
- dout1_im  in  32  FFT output 1, imaginary part
- dout2_re  in  32  FFT output 2, real part
- dout2_im  in  32  FFT output 2, imaginary part
- freeze  in  1  high blocks capture of new results
- next_word  in  1  level input; rising edge requests a word advance
- auto_rotate  in  1  high enables timed word rotation
- an  out  3  digit index driven to the display
- d  out  4  nibble for the current digit
- seg  out  7  active-low segments, seg[0]=a … seg[6]=g
- word_sel  out  2  displayed word (0=out1 Re, 1=out1 Im, 2=out2 Re, 3=out2 Im)
- snap_valid  out  1  sticky; at least one snapshot is on display

Behaviour:
- Reset (synchronous, active-high): all registers clear to 0, including:
  - shadow and display words, shadow_new, refresh counter, digit, frame counter, word_sel, pending advance, next_word edge register.
  - Outputs: an=0, d=0, seg=7'b1000000 (glyph "0"), snap_valid=0.
  - Reset asserted mid-frame or mid-hold aborts immediately, with no partial update.
- Capture: on any cycle with out_valid=1 and freeze=0, all four inputs load into shadow registers and shadow_new is set.
  - Consecutive valid cycles overwrite the shadow; the last value wins.
- Refresh counter: counts 0..REFRESH_DIV-1 and wraps to 0. tick = (counter == REFRESH_DIV-1).
  - On tick, digit increments 0..7 and wraps 7→0.
- Frame end: tick while digit == 7.
- Snapshot transfer, at frame end only:
  - If shadow_new=1, the display words load from the shadow, shadow_new clears and snap_valid sets.
  - If a capture coincides with frame end, the transfer takes the pre-capture shadow, and shadow_new stays set so the new data goes out at the next frame end.
  - The display never changes mid-frame.
- next_word edge: registered once; a rising edge sets pending_adv. pending_adv holds until frame end.
- Word advance, at frame end:
  - Auto event: auto_rotate=1 and frame_cnt == WORD_HOLD-1.
  - If pending_adv or the auto event occurs: word_sel increments (wraps 3→0), frame_cnt clears, pending_adv clears.
  - Both occurring together advance by exactly one word.
  - Otherwise frame_cnt increments, saturating at WORD_HOLD-1.
  - frame_cnt also counts with auto_rotate=0, so enabling auto_rotate at saturation rotates at the next frame end.
- Nibble select: nibble = display_word[word_sel][4*digit+3 : 4*digit]. Digit 0 is the least significant nibble.
- Output registering: an, d and seg are registered from the digit, word_sel and display registers, so they lag a digit change by 1 clock. word_sel and snap_valid are driven directly from their registers.
- Segment decode (g..a, active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Before the first transfer the display words are 0, so every digit shows "0" while snap_valid=0.

Test Plan:
- Reset, then 20 idle cycles with REFRESH_DIV=4 → an steps 0,1,2,… every 4 clocks (1-cycle lag after tick); d=0; seg=1000000; snap_valid=0.
- One out_valid pulse with dout1_re=32'h89ABCDEF, REFRESH_DIV=4, word_sel=0:
  - Nothing changes until frame end; snap_valid then rises.
  - The next frame shows d = F,E,D,C,B,A,9,8 for an = 0..7, with seg for F = 0001110 and for 8 = 0000000.
- freeze=1 with out_valid pulses of a different value → display and shadow unchanged; snap_valid unchanged.
- next_word rising edge mid-frame (auto_rotate=0) → word_sel increments exactly once at the next frame end. Holding next_word high for 3 frames still advances only once.
- auto_rotate=1, WORD_HOLD=2, REFRESH_DIV=4 → word_sel cycles 0,1,2,3,0, advancing every 2 frames (64 clocks). A next_word edge landing on an auto frame end advances by one only, then the hold restarts.
- Capture on the exact frame-end cycle, plus reset asserted mid-frame:
  - The capture is displayed one frame later.
  - Reset returns an=0, d=0, seg=1000000, word_sel=0, snap_valid=0 on the next clock.
